// File: rtl/readout_sequencer.sv
// readout_sequencer: exposes a serial pixel chain, shifts each counter word out MSB first and offers it on valid/ready.
// Define LFSR_DECODE_EN to convert raw LFSR counter words into binary counts before they are offered.
module readout_sequencer #(
    parameter int CNT_W = 8,
    parameter int N_PIX = 16,
    parameter int EXP_W = 16,
    localparam int PIX_W = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
    input  logic             clk_read,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exposeCycles,
    output logic             shutter,
    output logic             shiftEn,
    input  logic             SerIn,
    output logic             SerOut,
    output logic [CNT_W-1:0] dataOut,
    output logic [PIX_W-1:0] pixelIdx,
    output logic             dataValid,
    input  logic             dataReady,
    output logic             decErr,
    output logic             busy,
    output logic             frameDone
);
    localparam int BIT_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CNT_W - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(N_PIX - 1);
`ifdef LFSR_DECODE_EN
    typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_SETTLE, S_SHIFT, S_DECODE, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_EXPOSE, S_SETTLE, S_SHIFT, S_HOLD} state_t;
`endif
    state_t r_state, w_next;
    logic [EXP_W-1:0] r_exp_len, r_cnt;
    logic [BIT_W-1:0] r_bit;
    logic [PIX_W-1:0] r_pix;
    logic [CNT_W-1:0] r_sr;
    logic             r_done;
    logic             w_shutter, w_shift, w_valid, w_accept, w_last_bit, w_last_pix;
`ifdef LFSR_DECODE_EN
    logic [CNT_W-1:0] r_lfsr, r_dcnt, r_data;
    logic             r_err;
    logic             w_hit, w_miss;
    assign w_hit  = r_lfsr == r_sr;
    assign w_miss = &r_dcnt;
`endif
    assign w_last_bit = r_bit == LAST_BIT;
    assign w_last_pix = r_pix == LAST_PIX;
    assign w_accept   = (r_state == S_HOLD) && dataReady;

    always_ff @(posedge clk_read) r_state <= reset ? S_IDLE : w_next;

    always_comb begin
        w_next    = r_state;
        w_shutter = 1'b0;
        w_shift   = 1'b0;
        w_valid   = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_EXPOSE;
            S_EXPOSE: begin
                w_shutter = 1'b1;
                if (r_cnt == r_exp_len - EXP_W'(1)) w_next = S_SETTLE;
            end
            S_SETTLE: if (r_cnt == EXP_W'(1)) w_next = S_SHIFT;
            S_SHIFT: begin
                w_shift = 1'b1;
`ifdef LFSR_DECODE_EN
                if (w_last_bit) w_next = S_DECODE;
`else
                if (w_last_bit) w_next = S_HOLD;
`endif
            end
`ifdef LFSR_DECODE_EN
            S_DECODE: if (w_hit || w_miss) w_next = S_HOLD;
`endif
            S_HOLD: begin
                w_valid = 1'b1;
                if (dataReady) w_next = w_last_pix ? S_IDLE : S_SHIFT;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_read) begin
        if (reset) begin
            r_exp_len <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_pix     <= '0;
            r_sr      <= '0;
            r_done    <= 1'b0;
`ifdef LFSR_DECODE_EN
            r_lfsr    <= '0;
            r_dcnt    <= '0;
            r_data    <= '0;
            r_err     <= 1'b0;
`endif
        end else begin
            r_done <= w_accept && w_last_pix;
            if (r_state == S_IDLE && start) r_exp_len <= (exposeCycles == '0) ? EXP_W'(1) : exposeCycles;
            // one counter times both EXPOSE and SETTLE; it rests at zero everywhere else
            r_cnt <= ((r_state == S_EXPOSE || r_state == S_SETTLE) && w_next == r_state) ? r_cnt + EXP_W'(1) : '0;
            if (w_shift) begin
                r_sr  <= {r_sr[CNT_W-2:0], SerIn};
                r_bit <= w_last_bit ? '0 : r_bit + BIT_W'(1);
            end
`ifdef LFSR_DECODE_EN
            if (w_shift) begin
                r_lfsr <= '1;
                r_dcnt <= '0;
            end else if (r_state == S_DECODE) begin
                if (w_hit) begin
                    r_data <= r_dcnt;
                    r_err  <= 1'b0;
                end else if (w_miss) begin
                    r_data <= '1;
                    r_err  <= 1'b1;
                end else begin
                    r_lfsr <= {r_lfsr[CNT_W-2:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
                    r_dcnt <= r_dcnt + CNT_W'(1);
                end
            end
`endif
            if (w_accept) r_pix <= w_last_pix ? '0 : r_pix + PIX_W'(1);
        end
    end

    assign shutter   = w_shutter;
    assign shiftEn   = w_shift;
    assign dataValid = w_valid;
    assign busy      = r_state != S_IDLE;
    assign frameDone = r_done;
    assign SerOut    = 1'b0;
    assign pixelIdx  = r_pix;
`ifdef LFSR_DECODE_EN
    assign dataOut   = r_data;
    assign decErr    = r_err;
`else
    assign dataOut   = r_sr;
    assign decErr    = 1'b0;
`endif
endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: bench for readout_sequencer with a 4-pixel chain model and a word scoreboard.
`timescale 1ns/1ps
module tb_readout_sequencer;
    localparam int CNT_W = 8;
    localparam int N_PIX = 4;
    localparam int EXP_W = 16;
    typedef struct { logic [7:0] d; logic [1:0] idx; logic err; } exp_t;

    logic             clk_read = 1'b0;
    logic             reset = 1'b1, start = 1'b0, SerIn = 1'b0, dataReady = 1'b0;
    logic [EXP_W-1:0] exposeCycles = '0;
    logic             shutter, shiftEn, SerOut, dataValid, decErr, busy, frameDone;
    logic [CNT_W-1:0] dataOut;
    logic [1:0]       pixelIdx;
    int checks = 0, fails = 0, cyc = 0, bit_ptr = 0, rdy_mode = 0;
    int frames_exp = 0, frames_done = 0, first_shift = 0, last_acc = 0;
    bit done_pend = 1'b0;
    logic [7:0] chain [N_PIX];
    exp_t exp_q[$];
    int dec_tab [256];

    readout_sequencer #(.CNT_W(CNT_W), .N_PIX(N_PIX), .EXP_W(EXP_W)) dut (
        .clk_read(clk_read), .reset(reset), .start(start), .exposeCycles(exposeCycles),
        .shutter(shutter), .shiftEn(shiftEn), .SerIn(SerIn), .SerOut(SerOut),
        .dataOut(dataOut), .pixelIdx(pixelIdx), .dataValid(dataValid), .dataReady(dataReady),
        .decErr(decErr), .busy(busy), .frameDone(frameDone)
    );

    always #5 clk_read = ~clk_read;
    always @(posedge clk_read) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Word-level model: raw count or its position in the maximal-length LFSR sequence from FF.
    function automatic exp_t model(input logic [7:0] raw, input int idx);
        exp_t e;
        e.idx = 2'(idx);
`ifdef LFSR_DECODE_EN
        e.err = (raw == 8'h00);
        e.d   = e.err ? 8'hFF : 8'(dec_tab[raw]);
`else
        e.err = 1'b0;
        e.d   = raw;
`endif
        return e;
    endfunction

    function automatic logic [7:0] rw();
        int r = $urandom_range(0, 9);
        return (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
    endfunction

`ifdef LFSR_DECODE_EN
    initial begin
        logic [7:0] s = 8'hFF;
        for (int k = 0; k < 255; k++) begin
            dec_tab[s] = k;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
    end
`endif

    always @(posedge clk_read) begin
        #1;
        dataReady = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Pixel chain: present the next bit while shiftEn is high; it is taken at the coming edge.
    always @(negedge clk_read) begin
        if (shiftEn && bit_ptr < N_PIX * CNT_W) begin
            SerIn = chain[bit_ptr / CNT_W][CNT_W - 1 - bit_ptr % CNT_W];
            bit_ptr++;
        end else SerIn = 1'b0;
    end

    always @(negedge clk_read) begin
        exp_t e;
        if (!reset) begin
            if (dataValid) chk("valid_only_in_hold", {shiftEn, shutter}, 2'b00);
            if (done_pend) chk("frameDone_after_last", frameDone, 1'b1);
            else if (frameDone) chk("frameDone_spurious", frameDone, 1'b0);
            if (frameDone) frames_done++;
            done_pend = 1'b0;
            if (dataValid && dataReady) begin
                chk("sb_has_entry", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("dataOut", dataOut, e.d);
                    chk("pixelIdx", pixelIdx, e.idx);
                    chk("decErr", decErr, e.err);
                    done_pend = (e.idx == 2'(N_PIX - 1));
                    last_acc = cyc;
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_shutter"}, shutter, 0);
        chk({tag, "_shiftEn"}, shiftEn, 0);
        chk({tag, "_dataValid"}, dataValid, 0);
        chk({tag, "_dataOut"}, dataOut, 0);
        chk({tag, "_pixelIdx"}, pixelIdx, 0);
        chk({tag, "_decErr"}, decErr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frameDone"}, frameDone, 0);
        chk({tag, "_SerOut"}, SerOut, 0);
    endtask

    task automatic start_frame(input int ex, input logic [7:0] w0, w1, w2, w3, input bit now);
        if (!now) @(negedge clk_read);
        chain[0] = w0; chain[1] = w1; chain[2] = w2; chain[3] = w3;
        bit_ptr = 0;
        for (int i = 0; i < N_PIX; i++) exp_q.push_back(model(chain[i], i));
        frames_exp++;
        exposeCycles = EXP_W'(ex);
        start = 1'b1;
        @(negedge clk_read);
        start = 1'b0;
    endtask

    task automatic measure(input int ex);
        int n = 0, g = 0, s = 0;
        while (shutter && n < 1000) begin n++; @(negedge clk_read); end
        while (!shiftEn && g < 100) begin g++; @(negedge clk_read); end
        first_shift = cyc;
        while (shiftEn && s < 100) begin s++; @(negedge clk_read); end
        chk("shutter_cycles", n, (ex == 0) ? 1 : ex);
        chk("settle_cycles", g, 2);
        chk("first_word_shifts", s, CNT_W);
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 5000) begin t++; @(negedge clk_read); end
        chk({tag, "_drained"}, exp_q.size(), 0);
        chk({tag, "_idle"}, busy, 0);
        @(negedge clk_read);
        chk({tag, "_frames"}, frames_done, frames_exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n;
        repeat (3) @(negedge clk_read);
        check_idle("reset");
        reset = 1'b0;
        @(negedge clk_read);
        check_idle("post_reset");

        rdy_mode = 0;
        start_frame(5, 8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b0);
        measure(5);
        wait_done("basic");
`ifndef LFSR_DECODE_EN
        chk("frame_cycles", last_acc - first_shift + 1, 36);
`endif

        start_frame(0, rw(), rw(), rw(), rw(), 1'b0);
        measure(0);
        wait_done("zero_exp");

        rdy_mode = 1;
        start_frame(3, 8'hFF, 8'hFE, 8'h00, 8'h80, 1'b0);
        measure(3);
        wait_done("decode");

        rdy_mode = 0;
        start_frame(2, 8'h5A, 8'hC3, 8'h96, 8'h0F, 1'b0);
        measure(2);
        t = 0;
        while (!(shiftEn && pixelIdx == 2'd1) && t < 500) begin t++; @(negedge clk_read); end
        rdy_mode = 2;
        t = 0;
        while (!dataValid && t < 500) begin t++; @(negedge clk_read); end
        for (int i = 0; i < 20; i++) begin
            chk("stall_valid", dataValid, 1);
            chk("stall_dataOut", dataOut, model(8'hC3, 1).d);
            chk("stall_pixelIdx", pixelIdx, 1);
            chk("stall_shiftEn", shiftEn, 0);
            @(negedge clk_read);
        end
        rdy_mode = 0;
        wait_done("stall");

        rdy_mode = 1;
        start_frame(1, rw(), rw(), rw(), rw(), 1'b0);
        t = 0;
        while (!frameDone && t < 5000) begin t++; @(negedge clk_read); end
        chk("b2b_done_seen", frameDone, 1);
        start_frame(2, rw(), rw(), rw(), rw(), 1'b1);
        chk("b2b_start_taken", busy, 1);
        measure(2);
        wait_done("b2b");

        rdy_mode = 0;
        start_frame(4, rw(), rw(), rw(), rw(), 1'b0);
        t = 0;
        while (!(shiftEn && pixelIdx == 2'd2) && t < 500) begin t++; @(negedge clk_read); end
        repeat (3) @(negedge clk_read);
        chk("abort_in_shift", shiftEn, 1);
        reset = 1'b1;
        exp_q.delete();
        frames_exp--;
        @(negedge clk_read);
        reset = 1'b0;
        check_idle("abort");
        start_frame(6, rw(), rw(), rw(), rw(), 1'b0);
        n = 0;
        while (shutter && n < 1000) begin n++; start = (n == 3); @(negedge clk_read); end
        start = 1'b0;
        chk("restart_shutter", n, 6);
        wait_done("restart");
        repeat (3) @(negedge clk_read);
        chk("no_ghost_frame", busy, 0);

        rdy_mode = 1;
        for (int f = 0; f < 6; f++) begin
            int e = $urandom_range(0, 4);
            start_frame(e, rw(), rw(), rw(), rw(), 1'b0);
            measure(e);
            wait_done("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
